// File: rtl/voxel_ram.sv
// ---------------------------------------------------------------------------
// voxel_ram
// 32x32x32 occupancy grid, stored as 1024 words of 32 bits, read one voxel
// at a time by the DDA traversal engine and loaded one word at a time.
// A built-in clear engine zeroes the whole grid after reset or on request.
// While a clear runs, every read returns 0, so words not yet cleared are
// never visible.
//
// Parameters
//   SYNC_READ   1 = voxel_solid registered (1-cycle latency, read-first)
//               0 = voxel_solid combinational from voxel_addr
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   voxel_addr   in   [14:0] {iz, iy, ix} voxel read address
//   voxel_solid  out  occupancy bit of the addressed voxel
//   wr_valid     in   load-port write request
//   wr_ready     out  load port accepts a word this cycle
//   wr_addr      in   [9:0] word address {iz, iy}
//   wr_data      in   [31:0] occupancy bits, bit n = voxel ix = n
//   clr_start    in   single-cycle request to zero the whole grid
//   busy         out  clear in progress
//   clr_done     out  one-cycle pulse on the final clear write
// ---------------------------------------------------------------------------
module voxel_ram #(
   parameter int unsigned SYNC_READ = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [14:0] voxel_addr,
   output logic        voxel_solid,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [9:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        clr_start,
   output logic        busy,
   output logic        clr_done
);

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 32;
   localparam int unsigned BW    = 5;
   localparam int unsigned WORDS = 1024;

   localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   state_e           state_q,   state_d;
   logic [AW-1:0]    clr_ptr_q, clr_ptr_d;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [DW-1:0]    mem_wdata;
   logic             wr_ready_c;
   logic             clr_done_c;

   logic [DW-1:0]    mem_q [WORDS];

   logic [AW-1:0]    rd_word_addr;
   logic [BW-1:0]    rd_bit_addr;
   logic [DW-1:0]    rd_word;
   logic             rd_bit_masked;

   // State register and clear pointer
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Next-state, write-port steering and handshake outputs
   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      mem_we     = 1'b0;
      mem_waddr  = wr_addr;
      mem_wdata  = wr_data;
      wr_ready_c = 1'b0;
      clr_done_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A clear request takes priority over a coincident load write.
            wr_ready_c = !clr_start;
            if (clr_start) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end else if (wr_valid) begin
               mem_we = 1'b1;
            end
         end

         ST_CLEAR: begin
            // One word per cycle; clr_start is ignored here on purpose.
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == LAST_WORD) begin
               clr_done_c = 1'b1;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
         end
      endcase

      // Reset abandons any in-flight write or clear immediately.
      if (reset) begin
         mem_we     = 1'b0;
         wr_ready_c = 1'b0;
         clr_done_c = 1'b0;
      end
   end

   assign wr_ready = wr_ready_c;
   assign clr_done = clr_done_c;
   assign busy     = (state_q == ST_CLEAR);

   // Grid storage: no reset, only the clear engine zeroes it
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Voxel lookup: upper bits pick the word, lower bits pick ix
   assign rd_word_addr  = voxel_addr[14:5];
   assign rd_bit_addr   = voxel_addr[4:0];
   assign rd_word       = mem_q[rd_word_addr];
   assign rd_bit_masked = rd_word[rd_bit_addr] && (state_q == ST_IDLE);

   generate
      if (SYNC_READ != 0) begin : g_sync_read
         logic rd_q;

         // Read-first: samples contents before a same-edge write lands
         always_ff @(posedge clock) begin
            if (reset) begin
               rd_q <= 1'b0;
            end else begin
               rd_q <= rd_bit_masked;
            end
         end

         assign voxel_solid = rd_q;
      end else begin : g_comb_read
         assign voxel_solid = rd_bit_masked;
      end
   endgenerate

endmodule

// File: tb/tb_voxel_ram.sv
// ---------------------------------------------------------------------------
// tb_voxel_ram
// Scoreboard bench for voxel_ram (SYNC_READ=1). The driver applies one cycle
// of stimulus, derives the expected outputs from a word-array model of the
// grid plus a "cycles of clear remaining" counter, and queues them; a
// monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_voxel_ram;

   localparam int unsigned CLEAR_CYCLES = 1024;

   logic        clock = 1'b0;
   logic        reset;
   logic [14:0] voxel_addr;
   logic        voxel_solid;
   logic        wr_valid;
   logic        wr_ready;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic        clr_start;
   logic        busy;
   logic        clr_done;

   always #5 clock = ~clock;

   voxel_ram #(.SYNC_READ(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .voxel_addr  (voxel_addr),
      .voxel_solid (voxel_solid),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .clr_start   (clr_start),
      .busy        (busy),
      .clr_done    (clr_done)
   );

   typedef struct {
      bit ready;
      bit busy;
      bit done;
      bit solid;
      bit solid_chk;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;

   // Reference model: grid contents and remaining clear cycles
   bit [31:0]   model_mem [1024];
   int          clear_left    = 0;
   bit          exp_solid     = 1'b0;
   bit          exp_solid_vld = 1'b0;
   bit          chk_en        = 1'b0;
   int          done_pulses   = 0;

   task automatic check1(input string name, input logic act, input bit exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares mid-cycle, decoupled from the driver
   always @(negedge clock) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check1("wr_ready", wr_ready, e.ready);
         check1("busy",     busy,     e.busy);
         check1("clr_done", clr_done, e.done);
         if (e.solid_chk) check1("voxel_solid", voxel_solid, e.solid);
      end
   end

   function automatic logic [14:0] vaddr(input int iz, input int iy, input int ix);
      return {5'(iz), 5'(iy), 5'(ix)};
   endfunction

   task automatic model_zero();
      for (int w = 0; w < 1024; w++) model_mem[w] = 32'h0;
   endtask

   // One clock of stimulus; expectation queued, model advanced at the edge
   task automatic cycle(input bit rst, input bit start, input bit wv,
                        input logic [9:0] wa, input logic [31:0] wd,
                        input logic [14:0] va);
      exp_t e;
      bit   busy_pre;
      bit   accept;
      logic [31:0] rd_word;
      reset      = rst;
      clr_start  = start;
      wr_valid   = wv;
      wr_addr    = wa;
      wr_data    = wd;
      voxel_addr = va;

      busy_pre    = (clear_left > 0);
      e.busy      = busy_pre;
      e.ready     = !busy_pre && !start && !rst;
      e.done      = (clear_left == 1) && !rst;
      e.solid     = exp_solid;
      e.solid_chk = exp_solid_vld;
      accept      = e.ready && wv;
      if (chk_en) begin
         sb_q.push_back(e);
         if (e.done) done_pulses++;
      end

      @(posedge clock);
      if (rst) begin
         clear_left = CLEAR_CYCLES;
         model_zero();
         exp_solid = 1'b0;
      end else begin
         rd_word   = model_mem[va[14:5]];
         exp_solid = busy_pre ? 1'b0 : rd_word[va[4:0]];
         if (busy_pre) begin
            clear_left--;
         end else if (start) begin
            clear_left = CLEAR_CYCLES;
            model_zero();
         end else if (accept) begin
            model_mem[wa] = wd;
         end
      end
      exp_solid_vld = 1'b1;
      #1;
   endtask

   // Idle cycles with random reads and random (ignored) write payloads
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, 1'b0, 10'($urandom), $urandom, 15'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses_before;
      reset = 1'b1; clr_start = 1'b0; wr_valid = 1'b0;
      wr_addr = '0; wr_data = '0; voxel_addr = '0;
      #1;

      // Power-up reset; state is unknown until the first edge
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
      chk_en = 1'b1;
      cycle(1'b1, 1'b0, 1'b1, 10'h3, 32'hFFFF_FFFF, '0);

      // Automatic clear after release, then every read is 0
      pulses_before = done_pulses;
      idle(CLEAR_CYCLES + 8);
      total++;
      if (done_pulses - pulses_before != 1) begin
         bad++;
         $display("FAIL reset_clear_pulses: got %0d expected 1", done_pulses - pulses_before);
      end

      // Word 0x021 = 8000_0001: ix 0 and 31 solid, ix 1 empty
      cycle(1'b0, 1'b0, 1'b1, 10'h021, 32'h8000_0001, vaddr(1, 1, 0));
      cycle(1'b0, 1'b0, 1'b0, '0, '0, vaddr(1, 1, 0));
      cycle(1'b0, 1'b0, 1'b0, '0, '0, vaddr(1, 1, 31));
      cycle(1'b0, 1'b0, 1'b0, '0, '0, vaddr(1, 1, 1));
      idle(2);

      // Read-first collision on word 5
      cycle(1'b0, 1'b0, 1'b1, 10'd5, 32'hFFFF_FFFF, vaddr(0, 5, 3));
      cycle(1'b0, 1'b0, 1'b0, '0, '0, vaddr(0, 5, 3));
      idle(2);

      // Randomised traffic in a small region so reads hit written words
      for (int i = 0; i < 400; i++) begin
         bit st;
         bit wv;
         st = ($urandom_range(0, 149) == 0);
         wv = ($urandom_range(0, 9) < 7);
         cycle(1'b0, st, wv,
               {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, $urandom,
               vaddr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31)));
      end
      idle(CLEAR_CYCLES + 4);

      // Clear and write in the same idle cycle: clear wins
      cycle(1'b0, 1'b0, 1'b1, 10'h021, 32'h8000_0001, '0);
      cycle(1'b0, 1'b1, 1'b1, 10'h021, 32'hFFFF_FFFF, vaddr(1, 1, 5));
      idle(CLEAR_CYCLES + 2);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, vaddr(1, 1, 0));
      cycle(1'b0, 1'b0, 1'b0, '0, '0, vaddr(1, 1, 31));
      idle(1);

      // Second clr_start at clear cycle 500 must not extend the clear
      cycle(1'b0, 1'b0, 1'b1, 10'h042, 32'h0000_00F0, '0);
      cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
      idle(499);
      cycle(1'b0, 1'b1, 1'b0, '0, '0, vaddr(2, 2, 4));
      pulses_before = done_pulses;
      idle(CLEAR_CYCLES - 500 + 6);
      total++;
      if (done_pulses - pulses_before != 1) begin
         bad++;
         $display("FAIL restart_ignored_pulses: got %0d expected 1", done_pulses - pulses_before);
      end

      // Reset for 2 cycles at clear cycle 300 restarts a full clear
      cycle(1'b0, 1'b0, 1'b1, 10'h3FF, 32'h8000_0000, '0);
      cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
      idle(299);
      cycle(1'b1, 1'b0, 1'b1, 10'h3FF, 32'hFFFF_FFFF, '0);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
      idle(CLEAR_CYCLES + 4);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, vaddr(31, 31, 31));
      idle(3);

      // Scoreboard must be fully drained
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/voxel_ram.md
VOXEL_RAM -- requirements
Module: voxel_ram

Interface
REQ-001 Parameter: SYNC_READ, default 1, read latency. 1 = voxel_solid registered (1 cycle); 0 = combinational.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 voxel_addr  input  15  voxel read address {iz[4:0], iy[4:0], ix[4:0]}, driven by the DDA traversal engine.
REQ-005 voxel_solid  output  1  occupancy bit of the addressed voxel (1 = solid).
REQ-006 wr_valid  input  1  load-port word write request.
REQ-007 wr_ready  output  1  load port can accept a word this cycle.
REQ-008 wr_addr  input  10  word address {iz, iy}.
REQ-009 wr_data  input  32  occupancy bits; bit n = voxel with ix = n.
REQ-010 clr_start  input  1  single-cycle request to zero the whole grid.
REQ-011 busy  output  1  clear in progress.
REQ-012 clr_done  output  1  one-cycle pulse on the final clear write.

Function
REQ-013 Storage SHALL be 1024 words x 32 bits (32x32x32 voxels); contents are not reset directly and are zeroed only by the clear engine.
REQ-014 Read mapping SHALL be word = voxel_addr[14:5], bit = voxel_addr[4:0].
REQ-015 SYNC_READ=1: voxel_solid SHALL equal the bit sampled at the previous rising edge, i.e. 1-cycle latency.
REQ-016 SYNC_READ=0: voxel_solid SHALL be combinational from voxel_addr and current contents.
REQ-017 The FSM SHALL have two states: IDLE and CLEAR, plus a 10-bit clear pointer clr_ptr.
REQ-018 In CLEAR, each cycle SHALL write 32'h0 to word clr_ptr and increment clr_ptr.
REQ-019 In CLEAR, when clr_ptr == 1023, the FSM SHALL write that word, assert clr_done for that cycle, and move to IDLE. A clear takes exactly 1024 cycles.
REQ-020 In IDLE, clr_start = 1 SHALL move the FSM to CLEAR with clr_ptr = 0.
REQ-021 clr_start SHALL be ignored while in CLEAR; no restart and no pointer reset.
REQ-022 busy SHALL be 1 exactly when the state is CLEAR.
REQ-023 wr_ready SHALL be (state == IDLE) && !clr_start; when clr_start and wr_valid coincide, the clear wins and the write is not accepted.
REQ-024 A write is accepted when wr_valid && wr_ready, and mem[wr_addr] SHALL take wr_data at that edge. One word per cycle, no internal buffering.
REQ-025 Read-during-write to the same word:
  - SYNC_READ=1: read-first; voxel_solid shows the old bit, and the new bit from the next sampled read.
  - SYNC_READ=0: the new bit shows from the cycle after acceptance.
REQ-026 voxel_solid SHALL be 0 for any read sampled (SYNC_READ=1) or presented (SYNC_READ=0) while busy = 1, so that uncleared words are never exposed.
REQ-027 wr_addr and wr_data SHALL be ignored when no write is accepted; voxel_addr has no valid qualifier and is sampled every cycle.

Reset
REQ-028 While reset = 1: state = CLEAR, clr_ptr = 0, busy = 1, wr_ready = 0, clr_done = 0, voxel_solid register = 0.
REQ-029 After reset deasserts, an automatic full clear SHALL run: clr_done pulses on the 1024th cycle after release, and wr_ready = 1 from the next cycle.
REQ-030 Reset asserted mid-clear or mid-write SHALL abandon the operation and restart per REQ-028, with no partial-state carry-over.

Verification
REQ-031 Reset release -> busy = 1 for 1024 cycles; single clr_done pulse on the last; wr_ready rises the cycle after; a read of any address returns 0.
REQ-032 Write wr_addr = 10'h021, wr_data = 32'h8000_0001 -> with SYNC_READ=1, addr {iz=1, iy=1, ix=0} and {1,1,31} read 1 one cycle after presentation; {1,1,1} reads 0.
REQ-033 Same-cycle write word 5 = 32'hFFFF_FFFF and read addr {0,5,3} (old 0) -> voxel_solid = 0 next cycle; re-read -> 1.
REQ-034 clr_start and wr_valid in the same IDLE cycle -> wr_ready = 0, write dropped, busy = 1 next cycle; after clr_done, the written word reads 0.
REQ-035 clr_start pulsed again mid-clear (cycle 500) -> clr_done still occurs at cycle 1024 of the original clear; busy never re-extends.
REQ-036 Reset asserted at clear cycle 300 for 2 cycles -> a full 1024-cycle clear restarts from clr_ptr = 0.
